// File: rtl/dab_pwm_modulator.sv
// Phase-shift PWM modulator for a dual-active-bridge: carrier, double-buffered tau1/tau2/phi,
// per-leg dead time. Define DAB_SYNC_EN to let a rising edge on sync restart the carrier.
module dab_pwm_modulator #(
  parameter int PERIOD      = 1000,
  parameter int DEADTIME    = 20,
  parameter int W           = 11,
  parameter int TRIG_OFFSET = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         sync,
  input  logic         param_valid,
  input  logic [W-1:0] tau1_in,
  input  logic [W-1:0] tau2_in,
  input  logic [W-1:0] phi_in,
  output logic         param_ack,
  output logic [3:0]   sp,
  output logic [3:0]   ss,
  output logic         trigger,
  output logic         period_start
);

  localparam int H  = PERIOD / 2;
  localparam int NW = $clog2(PERIOD);
  localparam int CW = W + 2;  // signed room for cnt - (phi + tau2) before the wrap correction
  localparam int DW = $clog2(DEADTIME + 1);
  localparam logic [W-1:0]         H_U = W'(H);
  localparam logic signed [CW-1:0] H_C = CW'(H);
  localparam logic signed [CW-1:0] P_S = CW'(PERIOD);

  logic [NW-1:0] cnt_reg, cnt_next;
  logic          boundary, sync_edge;
  logic signed [CW-1:0] tau1_act_reg, tau2_act_reg, phi_act_reg;
  logic signed [CW-1:0] tau1_pend_reg, tau2_pend_reg, phi_pend_reg;
  logic                 pend_flag_reg;
  logic signed [CW-1:0] tau1_c, tau2_c, phi_s, phi_c, cnt_s;
  logic signed [CW-1:0] shift [4];
  logic [3:0]           upper, lower;

`ifdef DAB_SYNC_EN
  logic sync_meta_reg, sync_sync_reg, sync_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_reg <= 1'b0;
      sync_sync_reg <= 1'b0;
      sync_prev_reg <= 1'b0;
    end else begin
      sync_meta_reg <= sync;
      sync_sync_reg <= sync_meta_reg;
      sync_prev_reg <= sync_sync_reg;
    end
  end

  assign sync_edge = sync_sync_reg & ~sync_prev_reg;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign sync_edge   = 1'b0;
`endif

  // A sync edge coinciding with the natural wrap still yields a single boundary.
  assign boundary = (cnt_reg == NW'(PERIOD - 1)) | sync_edge;
  assign cnt_next = boundary ? '0 : cnt_reg + NW'(1);

  always_comb begin
    tau1_c = (tau1_in > H_U) ? H_C : {2'b00, tau1_in};
    tau2_c = (tau2_in > H_U) ? H_C : {2'b00, tau2_in};
    phi_s  = {{2{phi_in[W-1]}}, phi_in};
    phi_c  = phi_s;
    if (phi_s > H_C)       phi_c = H_C;
    else if (phi_s < -H_C) phi_c = -H_C;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      tau1_act_reg  <= '0;
      tau2_act_reg  <= '0;
      phi_act_reg   <= '0;
      tau1_pend_reg <= '0;
      tau2_pend_reg <= '0;
      phi_pend_reg  <= '0;
      pend_flag_reg <= 1'b0;
      param_ack     <= 1'b0;
      trigger       <= 1'b0;
      period_start  <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      trigger      <= (cnt_next == NW'(TRIG_OFFSET));
      period_start <= boundary;
      param_ack    <= boundary & pend_flag_reg;
      if (boundary && pend_flag_reg) begin
        tau1_act_reg  <= tau1_pend_reg;
        tau2_act_reg  <= tau2_pend_reg;
        phi_act_reg   <= phi_pend_reg;
        pend_flag_reg <= 1'b0;
      end
      // A strobe on the boundary edge refills pending after the older set was applied.
      if (param_valid) begin
        tau1_pend_reg <= tau1_c;
        tau2_pend_reg <= tau2_c;
        phi_pend_reg  <= phi_c;
        pend_flag_reg <= 1'b1;
      end
    end
  end

  assign cnt_s    = {{(CW - NW){1'b0}}, cnt_reg};
  assign shift[0] = '0;
  assign shift[1] = tau1_act_reg;
  assign shift[2] = phi_act_reg;
  assign shift[3] = phi_act_reg + tau2_act_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_leg
      logic signed [CW-1:0] diff, wrapped;
      logic                 ideal, ideal_reg, upper_reg, lower_reg;
      logic [DW-1:0]        dt_reg, dt_eff;

      always_comb begin
        diff    = cnt_s - shift[gi];
        wrapped = diff;
        if (diff < 0)          wrapped = diff + P_S;
        else if (diff >= P_S)  wrapped = diff - P_S;
      end

      assign ideal  = (wrapped < H_C);
      // dt_reg holds the off-cycles still owed after this one; a toggle restarts the full gap.
      assign dt_eff = (ideal != ideal_reg) ? DW'(DEADTIME) : dt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          ideal_reg <= 1'b0;
          dt_reg    <= DW'(DEADTIME);
          upper_reg <= 1'b0;
          lower_reg <= 1'b0;
        end else begin
          ideal_reg <= ideal;
          if (!enable) begin
            dt_reg    <= DW'(DEADTIME);
            upper_reg <= 1'b0;
            lower_reg <= 1'b0;
          end else if (dt_eff != '0) begin
            dt_reg    <= dt_eff - DW'(1);
            upper_reg <= 1'b0;
            lower_reg <= 1'b0;
          end else begin
            dt_reg    <= '0;
            upper_reg <= ideal;
            lower_reg <= ~ideal;
          end
        end
      end

      assign upper[gi] = upper_reg;
      assign lower[gi] = lower_reg;
    end
  endgenerate

  assign sp = {upper[0], lower[0], upper[1], lower[1]};
  assign ss = {upper[2], lower[2], upper[3], lower[3]};

endmodule

// File: tb/tb_dab_pwm_modulator.sv
// Randomised bench for dab_pwm_modulator against a run-length reference model of the
// modulation and dead-time rules, plus directed edge-timing measurements.
module tb_dab_pwm_modulator;
  localparam int P    = 1000;
  localparam int D    = 20;
  localparam int W    = 11;
  localparam int TOFF = 37;
  localparam int H    = P / 2;

  logic         clk = 1'b0;
  logic         rst, enable, sync, param_valid;
  logic [W-1:0] tau1_in, tau2_in, phi_in;
  logic         param_ack, trigger, period_start;
  logic [3:0]   sp, ss;

  always #5 clk = ~clk;

  dab_pwm_modulator #(.PERIOD(P), .DEADTIME(D), .W(W), .TRIG_OFFSET(TOFF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync(sync), .param_valid(param_valid),
    .tau1_in(tau1_in), .tau2_in(tau2_in), .phi_in(phi_in), .param_ack(param_ack),
    .sp(sp), .ss(ss), .trigger(trigger), .period_start(period_start)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a gate conducts only after D+1 consecutive enabled decisions
  // with an unchanged ideal leg state.
  int m_cnt, en_run;
  int m_act[3], m_pend[3], same_run[4];
  bit m_pflag;
  bit last_ideal[4];
  bit [3:0] e_sp, e_ss;
  bit e_trig, e_ps, e_ack;

  function automatic int clamp_tau(input int v);
    return (v > H) ? H : v;
  endfunction

  function automatic int clamp_phi(input int raw);
    int v;
    v = (raw >= (1 << (W - 1))) ? raw - (1 << W) : raw;
    if (v > H) v = H;
    if (v < -H) v = -H;
    return v;
  endfunction

  function automatic bit ideal_of(input int c, input int s);
    int d;
    d = (c - s) % P;
    if (d < 0) d += P;
    return d < H;
  endfunction

  task automatic model_step();
    int s[4];
    bit id, on, wrap;
    bit up[4], lo[4];
    if (rst) begin
      m_cnt = 0; en_run = 0; m_pflag = 0;
      for (int i = 0; i < 3; i++) begin m_act[i] = 0; m_pend[i] = 0; end
      for (int l = 0; l < 4; l++) begin same_run[l] = 0; last_ideal[l] = 0; end
      e_sp = 0; e_ss = 0; e_trig = 0; e_ps = 0; e_ack = 0;
      return;
    end
    s[0] = 0; s[1] = m_act[0]; s[2] = m_act[2]; s[3] = m_act[2] + m_act[1];
    en_run = enable ? en_run + 1 : 0;
    for (int l = 0; l < 4; l++) begin
      id = ideal_of(m_cnt, s[l]);
      same_run[l] = (same_run[l] > 0 && id == last_ideal[l]) ? same_run[l] + 1 : 1;
      last_ideal[l] = id;
      on = (en_run > D) && (same_run[l] > D);
      up[l] = on && id;
      lo[l] = on && !id;
    end
    e_sp = {up[0], lo[0], up[1], lo[1]};
    e_ss = {up[2], lo[2], up[3], lo[3]};
    wrap = (m_cnt == P - 1);
    e_ack = wrap && m_pflag;
    if (e_ack) begin
      m_act = m_pend;
      m_pflag = 0;
    end
    if (param_valid) begin
      m_pend[0] = clamp_tau(int'(tau1_in));
      m_pend[1] = clamp_tau(int'(tau2_in));
      m_pend[2] = clamp_phi(int'(phi_in));
      m_pflag = 1;
    end
    m_cnt = wrap ? 0 : m_cnt + 1;
    e_ps = (m_cnt == 0);
    e_trig = (m_cnt == TOFF);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("sp", int'(sp), int'(e_sp));
    check("ss", int'(ss), int'(e_ss));
    check("trigger", int'(trigger), int'(e_trig));
    check("period_start", int'(period_start), int'(e_ps));
    check("param_ack", int'(param_ack), int'(e_ack));
    check("excl", int'((sp[3] & sp[2]) | (sp[1] & sp[0]) | (ss[3] & ss[2]) | (ss[1] & ss[0])), 0);
    param_valid = 1'b0;
  endtask

  task automatic strobe(input int t1, input int t2, input int ph);
    tau1_in = W'(t1);
    tau2_in = W'(t2);
    phi_in  = W'(ph);
    param_valid = 1'b1;
    $display("txn strobe tau1=%0d tau2=%0d phi=%0d at cnt=%0d", t1, t2, ph, m_cnt);
    cycle();
  endtask

  task automatic wait_cnt(input int target);
    for (int i = 0; i < 2 * P && m_cnt != target; i++) cycle();
    check("wait_cnt", m_cnt, target);
  endtask

  task automatic measure(output int hi_a, output int rise_a, output int rise_b, output int rise_c);
    logic [3:0] psp, pss;
    hi_a = 0; rise_a = -1; rise_b = -1; rise_c = -1;
    psp = sp; pss = ss;
    for (int i = 0; i < P; i++) begin
      cycle();
      if (sp[3]) hi_a++;
      if (sp[3] && !psp[3] && rise_a < 0) rise_a = i;
      if (sp[1] && !psp[1] && rise_b < 0) rise_b = i;
      if (ss[3] && !pss[3] && rise_c < 0) rise_c = i;
      psp = sp; pss = ss;
    end
  endtask

  task automatic count_off(input string tag);
    int n;
    n = 0;
    cycle();
    while (sp == 4'd0 && ss == 4'd0 && n < 100) begin
      n++;
      cycle();
    end
    check(tag, n, D);
  endtask

  initial begin
    int hi, ra, rb, rc, en_left;
    rst = 1'b1; enable = 1'b1; sync = 1'b0; param_valid = 1'b0;
    tau1_in = '0; tau2_in = '0; phi_in = '0;
    repeat (3) cycle();
    rst = 1'b0;
    count_off("reset_off");
    wait_cnt(0);

    // Symmetric duty, 100-count phase.
    wait_cnt(300);
    strobe(500, 500, 100);
    wait_cnt(0);
    measure(hi, ra, rb, rc);
    measure(hi, ra, rb, rc);
    check("sp1_high", hi, H - D);
    check("ss1_lag", rc - ra, 100);

    wait_cnt(300);
    strobe(250, 500, 100);
    wait_cnt(0);
    measure(hi, ra, rb, rc);
    measure(hi, ra, rb, rc);
    check("sp3_lag250", rb - ra, 250);

    // Last strobe in a period wins.
    wait_cnt(100);
    strobe(200, 500, 100);
    wait_cnt(400);
    strobe(300, 500, 100);
    wait_cnt(0);
    measure(hi, ra, rb, rc);
    measure(hi, ra, rb, rc);
    check("sp3_lag300", rb - ra, 300);

    // Out-of-range inputs clamp to H and -H.
    wait_cnt(300);
    strobe(900, 500, (1 << W) - 700);
    wait_cnt(0);
    measure(hi, ra, rb, rc);
    measure(hi, ra, rb, rc);
    check("clamp_tau1", rb - ra, H);
    check("clamp_phi", rc - ra, H);

    // Strobe on the wrap edge: older pending applied now, new one next period.
    wait_cnt(200);
    strobe(100, 500, 0);
    wait_cnt(P - 1);
    strobe(400, 500, 0);
    measure(hi, ra, rb, rc);
    check("wrap_old", rb - ra, 100);
    measure(hi, ra, rb, rc);
    check("wrap_new", rb - ra, 400);

    wait_cnt(200);
    enable = 1'b0;
    repeat (5) cycle();
    enable = 1'b1;
    count_off("reenable_off");

    // Reset mid-period discards the pending set.
    wait_cnt(500);
    strobe(50, 300, 20);
    wait_cnt(600);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    count_off("midreset_off");
    measure(hi, ra, rb, rc);
    measure(hi, ra, rb, rc);
    check("midreset_tau1", rb - ra, 0);

    en_left = 0;
    for (int i = 0; i < 20000; i++) begin
      sync = 1'($urandom);
      if (en_left > 0) begin
        en_left--;
        enable = (en_left == 0);
      end else if ($urandom_range(0, 1999) == 0) begin
        en_left = int'($urandom_range(1, 30));
        enable = 1'b0;
      end
      rst = ($urandom_range(0, 7999) == 0);
      if ($urandom_range(0, 249) == 0)
        strobe(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
               int'($urandom_range(0, (1 << W) - 1)));
      else
        cycle();
    end
    rst = 1'b0;
    enable = 1'b1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
